// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-requester arbiter and access sequencer for the byte-addressed data
//   memory (DM). Requester 0 is the core load/store unit and requester 1 is
//   a DMA/debug port. Requests are arbitrated round-robin. The granted
//   request's fields are latched, and the DM pins are driven from those
//   latches for one ACC cycle. The combinational DM read data is captured at
//   the end of ACC, then sign- or zero-extended into the requester's rdata
//   register. Each transaction completes with a one-cycle ack pulse.
//
// Handshake (valid/ready semantics):
//   mN_req acts as "valid". It must stay high with all mN_* fields stable
//   until mN_ack is seen high. mN_ack is a one-cycle completion pulse that
//   also acts as "ready". mN_err and mN_rdata are valid in the ack cycle.
//   mN_rdata keeps its value until the next load completes on that port.
//   A port that keeps req high through its ack cycle is masked for that
//   cycle, so the old request is never served twice.
//
// Access size codes (mN_size, dm_lwhb, dm_swhb):
//   2'b01 = byte, 2'b10 = halfword, 2'b11 = word, 2'b00 = no access.
//
// Optional feature:
//   `DMEM_ARB_MISALIGN_EN
//     When defined, misaligned H/W accesses are flagged at grant time. A
//     flagged access never reaches the DM, and it acks with mN_err = 1.
//     When undefined, every access goes to the DM and mN_err is tied to 0.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   mN_req/we/size/uns/addr/wdata   request from requester N (N = 0, 1)
//   mN_ack/err/rdata   completion pulse, error flag, extended load data
//   dm_memWrite        DM write enable
//   dm_lwhb, dm_swhb   DM load / store size
//   dm_addr, dm_wd     DM address / write data
//   dm_dt              DM combinational read data
//   fsm_state          debug view of the sequencer state (0 IDLE, 1 ACC)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW   = 10,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [1:0]      m0_size,
    input  logic            m0_uns,
    input  logic [AW-1:0]   m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [1:0]      m1_size,
    input  logic            m1_uns,
    input  logic [AW-1:0]   m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [XLEN-1:0] m1_rdata,

    output logic            dm_memWrite,
    output logic [1:0]      dm_lwhb,
    output logic [1:0]      dm_swhb,
    output logic [AW-1:0]   dm_addr,
    output logic [XLEN-1:0] dm_wd,
    input  logic [XLEN-1:0] dm_dt,

    output logic            fsm_state
);

    localparam logic [1:0] SL_B = 2'b01;
    localparam logic [1:0] SL_H = 2'b10;
    localparam logic [1:0] SL_W = 2'b11;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACC  = 1'b1;

    logic            state;
    logic            rr_last;       // index of the most recent grant
    logic            lat_idx;
    logic            lat_we;
    logic [1:0]      lat_size;
    logic            lat_uns;
    logic [AW-1:0]   lat_addr;
    logic [XLEN-1:0] lat_wdata;

    logic            cand0;
    logic            cand1;
    logic            gnt_idx;
    logic            sel_we;
    logic [1:0]      sel_size;
    logic            sel_uns;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_wdata;

    logic            acc_live;      // ACC cycle that actually touches the DM
    logic [XLEN-1:0] ld_data;

    assign fsm_state = state;

    // A request that is still high during its own ack cycle is the one that
    // was just served, so the ack masks it out of arbitration.
    assign cand0 = m0_req & ~m0_ack;
    assign cand1 = m1_req & ~m1_ack;

    always_comb begin
        gnt_idx = 1'b0;
        if (cand0 && cand1) begin
            gnt_idx = ~rr_last;
        end else if (cand1) begin
            gnt_idx = 1'b1;
        end
        sel_we    = gnt_idx ? m1_we    : m0_we;
        sel_size  = gnt_idx ? m1_size  : m0_size;
        sel_uns   = gnt_idx ? m1_uns   : m0_uns;
        sel_addr  = gnt_idx ? m1_addr  : m0_addr;
        sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
    end

    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] d,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] r;
        r = d;
        case (size)
            SL_B:    r = {{(XLEN-8){~uns & d[7]}}, d[7:0]};
            SL_H:    r = {{(XLEN-16){~uns & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign ld_data = extend(dm_dt, lat_size, lat_uns);

`ifdef DMEM_ARB_MISALIGN_EN
    logic lat_bad;
    logic sel_bad;

    assign sel_bad = ((sel_size == SL_H) && sel_addr[0]) ||
                     ((sel_size == SL_W) && (sel_addr[1:0] != 2'b00));

    // A flagged access keeps the DM pins quiet, exactly as in IDLE.
    assign acc_live = (state == ST_ACC) && !lat_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_bad <= 1'b0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
        end else begin
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            if (state == ST_IDLE && (cand0 || cand1)) begin
                lat_bad <= sel_bad;
            end
            if (state == ST_ACC) begin
                if (lat_idx == 1'b0) begin
                    m0_err <= lat_bad;
                end else begin
                    m1_err <= lat_bad;
                end
            end
        end
    end
`else
    logic lat_bad;

    assign lat_bad  = 1'b0;
    assign acc_live = (state == ST_ACC);
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

    // DM pins depend only on state and the latches, never on mN_* inputs.
    always_comb begin
        dm_memWrite = 1'b0;
        dm_lwhb     = 2'b00;
        dm_swhb     = 2'b00;
        dm_addr     = '0;
        dm_wd       = '0;
        if (acc_live) begin
            dm_addr = lat_addr;
            dm_wd   = lat_wdata;
            if (lat_we) begin
                dm_memWrite = 1'b1;
                dm_swhb     = lat_size;
            end else begin
                dm_lwhb     = lat_size;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            rr_last   <= 1'b1;
            lat_idx   <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cand0 || cand1) begin
                        lat_idx   <= gnt_idx;
                        lat_we    <= sel_we;
                        lat_size  <= sel_size;
                        lat_uns   <= sel_uns;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        rr_last   <= gnt_idx;
                        state     <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    state <= ST_IDLE;
                    if (lat_idx == 1'b0) begin
                        m0_ack <= 1'b1;
                        if (!lat_we && !lat_bad) begin
                            m0_rdata <= ld_data;
                        end
                    end else begin
                        m1_ack <= 1'b1;
                        if (!lat_we && !lat_bad) begin
                            m1_rdata <= ld_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed testbench for dmem_arbiter with a byte-array DM model. Drivers
// push the expected {err, rdata} for each request into a per-port queue.
// A monitor pops one entry on every ack and compares it with the response.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW   = 10;
    localparam int XLEN = 32;
    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

`ifdef DMEM_ARB_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            m0_req, m0_we, m0_uns, m0_ack, m0_err;
    logic [1:0]      m0_size;
    logic [AW-1:0]   m0_addr;
    logic [XLEN-1:0] m0_wdata, m0_rdata;
    logic            m1_req, m1_we, m1_uns, m1_ack, m1_err;
    logic [1:0]      m1_size;
    logic [AW-1:0]   m1_addr;
    logic [XLEN-1:0] m1_wdata, m1_rdata;
    logic            dm_memWrite;
    logic [1:0]      dm_lwhb, dm_swhb;
    logic [AW-1:0]   dm_addr;
    logic [XLEN-1:0] dm_wd, dm_dt;
    logic            fsm_state;

    dmem_arbiter #(.AW(AW), .XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_uns(m0_uns),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_uns(m1_uns),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .m1_err(m1_err), .m1_rdata(m1_rdata),
        .dm_memWrite(dm_memWrite), .dm_lwhb(dm_lwhb), .dm_swhb(dm_swhb),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_dt(dm_dt),
        .fsm_state(fsm_state)
    );

    // ---------------- DM model ----------------
    logic [7:0]    mem [0:1023];
    logic [AW-1:0] ra1, ra2, ra3;

    always_comb begin
        ra1   = dm_addr + 10'd1;
        ra2   = dm_addr + 10'd2;
        ra3   = dm_addr + 10'd3;
        dm_dt = {mem[ra3], mem[ra2], mem[ra1], mem[dm_addr]};
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (dm_memWrite) begin
                mem[dm_addr] = dm_wd[7:0];
                if (dm_swhb != SZ_B) mem[ra1] = dm_wd[15:8];
                if (dm_swhb == SZ_W) begin
                    mem[ra2] = dm_wd[23:16];
                    mem[ra3] = dm_wd[31:24];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN:0]   exp_q0[$];
    logic [XLEN:0]   exp_q1[$];
    logic [XLEN-1:0] model_rd [2];
    int serve_q[$];
    int ack_cyc0[$];
    int acc_cnt = 0;
    int ack_cnt = 0;
    int mw_cnt  = 0;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [XLEN:0] e;
        if (dm_memWrite) mw_cnt++;
        if (dm_memWrite || dm_lwhb != 2'b00) acc_cnt++;
        if (m0_ack) begin
            ack_cnt++;
            serve_q.push_back(0);
            ack_cyc0.push_back(cyc);
            check("m0_ack_single_cycle", {63'd0, prev0}, 64'd0);
            if (exp_q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL m0_unexpected_ack: got ack with empty queue, required no ack");
            end else begin
                e = exp_q0.pop_front();
                check("m0_resp", {31'd0, m0_err, m0_rdata}, {31'd0, e});
            end
        end
        if (m1_ack) begin
            ack_cnt++;
            serve_q.push_back(1);
            check("m1_ack_single_cycle", {63'd0, prev1}, 64'd0);
            if (exp_q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL m1_unexpected_ack: got ack with empty queue, required no ack");
            end else begin
                e = exp_q1.pop_front();
                check("m1_resp", {31'd0, m1_err, m1_rdata}, {31'd0, e});
            end
        end
        prev0 = m0_ack;
        prev1 = m1_ack;
    end

    // ---------------- driver ----------------
    // exp_rd is used for loads; a store (or flagged access) expects rdata
    // to keep the value of the last completed load on that port.
    task automatic issue(input int p, input logic we, input logic [1:0] size,
                         input logic uns, input logic [AW-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic exp_err,
                         input logic [XLEN-1:0] exp_rd, input bit keep,
                         input bit chk_lat);
        int lat;
        bit got;
        logic [XLEN-1:0] rd;
        lat = 0;
        got = 1'b0;
        @(posedge clk); #1;
        if (!we && !exp_err) model_rd[p] = exp_rd;
        rd = model_rd[p];
        if (p == 0) begin
            m0_we = we; m0_size = size; m0_uns = uns; m0_addr = addr;
            m0_wdata = wdata; m0_req = 1'b1;
            exp_q0.push_back({exp_err, rd});
        end else begin
            m1_we = we; m1_size = size; m1_uns = uns; m1_addr = addr;
            m1_wdata = wdata; m1_req = 1'b1;
            exp_q1.push_back({exp_err, rd});
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL m%0d_ack_timeout: got no ack in 40 cycles, required ack", p);
        end else if (chk_lat) begin
            check($sformatf("m%0d_latency", p), 64'(lat), 64'd2);
        end
        if (!keep) begin
            @(posedge clk); #1;
            if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mw0, acc0, ak0;
        bit got;
        rstn = 1'b0;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_uns = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_uns = 0; m1_addr = 0; m1_wdata = 0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {60'd0, m0_ack, m1_ack, m0_err, m1_err}, 64'd0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        check("reset_state", {63'd0, fsm_state}, 64'd0);
        check("reset_dm_pins", {17'd0, dm_memWrite, dm_lwhb, dm_swhb, dm_addr, dm_wd}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // 1: store W then load W
        mw0 = mw_cnt;
        issue(0, 1'b1, SZ_W, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t1_store_write_cycles", 64'(mw_cnt - mw0), 64'd1);
        issue(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        check("t1_load_no_write", 64'(mw_cnt - mw0), 64'd1);
        check("t1_rdata", 64'(m0_rdata), 64'hDEADBEEF);
        check("t1_idle_dm_pins", {17'd0, dm_memWrite, dm_lwhb, dm_swhb, dm_addr, dm_wd}, 64'd0);

        // 2: byte/halfword extension on m1
        issue(1, 1'b1, SZ_B, 1'b0, 10'h020, 32'h12345680, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1, 1'b1, SZ_B, 1'b0, 10'h021, 32'h0000007F, 1'b0, 32'h0, 1'b0, 1'b1);
        issue(1, 1'b0, SZ_B, 1'b0, 10'h020, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1);
        issue(1, 1'b0, SZ_B, 1'b1, 10'h020, 32'h0, 1'b0, 32'h00000080, 1'b0, 1'b1);
        issue(1, 1'b0, SZ_H, 1'b0, 10'h020, 32'h0, 1'b0, 32'h00007F80, 1'b0, 1'b1);

        // 3: contention, both ports holding req
        serve_q.delete();
        fork
            begin
                issue(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
                issue(0, 1'b0, SZ_H, 1'b0, 10'h010, 32'h0, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0);
            end
            begin
                issue(1, 1'b0, SZ_B, 1'b0, 10'h021, 32'h0, 1'b0, 32'h0000007F, 1'b1, 1'b0);
                issue(1, 1'b0, SZ_H, 1'b0, 10'h020, 32'h0, 1'b0, 32'h00007F80, 1'b0, 1'b0);
            end
        join
        check("t3_ack_count", 64'(serve_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < serve_q.size()) check($sformatf("t3_order_%0d", i), 64'(serve_q[i]), 64'(i % 2));
        end

        // 4: single requester holding req over three loads
        ack_cyc0.delete();
        acc0 = acc_cnt;
        ak0  = ack_cnt;
        issue(0, 1'b0, SZ_B, 1'b0, 10'h013, 32'h0, 1'b0, 32'hFFFFFFDE, 1'b1, 1'b1);
        issue(0, 1'b0, SZ_B, 1'b1, 10'h010, 32'h0, 1'b0, 32'h000000EF, 1'b1, 1'b1);
        issue(0, 1'b0, SZ_H, 1'b1, 10'h012, 32'h0, 1'b0, 32'h0000DEAD, 1'b0, 1'b1);
        check("t4_ack_count", 64'(ack_cyc0.size()), 64'd3);
        if (ack_cyc0.size() == 3) begin
            check("t4_spacing_a", 64'(ack_cyc0[1] - ack_cyc0[0]), 64'd3);
            check("t4_spacing_b", 64'(ack_cyc0[2] - ack_cyc0[1]), 64'd3);
        end
        check("t4_acc_cycles", 64'(acc_cnt - acc0), 64'd3);
        check("t4_acc_eq_acks", 64'(acc_cnt - acc0), 64'(ack_cnt - ak0));

        // 5: misaligned word store
        mw0 = mw_cnt;
        issue(0, 1'b1, SZ_W, 1'b0, 10'h012, 32'h11223344, MIS_EN, 32'h0, 1'b0, 1'b1);
        check("t5_write_cycles", 64'(mw_cnt - mw0), MIS_EN ? 64'd0 : 64'd1);
        issue(0, 1'b0, SZ_W, 1'b0, 10'h010, 32'h0, 1'b0,
              MIS_EN ? 32'hDEADBEEF : 32'h3344BEEF, 1'b0, 1'b1);

        // 6: reset during the ACC of an m1 load
        @(posedge clk); #1;
        m1_we = 1'b0; m1_size = SZ_W; m1_uns = 1'b0; m1_addr = 10'h010; m1_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fsm_state) begin
                got = 1'b1;
                break;
            end
        end
        check("t6_reached_acc", {63'd0, got}, 64'd1);
        rstn = 1'b0;
        #1;
        model_rd[0] = '0;
        model_rd[1] = '0;
        check("t6_ack_after_abort", {62'd0, m0_ack, m1_ack}, 64'd0);
        check("t6_rdata_after_abort", {m0_rdata, m1_rdata}, 64'd0);
        check("t6_state_after_abort", {63'd0, fsm_state}, 64'd0);
        @(posedge clk); #1;
        m1_req = 1'b0;
        @(negedge clk);
        check("t6_no_ack_in_reset", {63'd0, m1_ack}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        issue(1, 1'b0, SZ_H, 1'b1, 10'h020, 32'h0, 1'b0, 32'h00007F80, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        check("q0_drained", 64'(exp_q0.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule
